issue_ctrl: RTL

In-order issue controller between the instruction decoder and the execution units. It holds one decoded instruction in an issue register and tracks pending destination writes in a 32-entry scoreboard. It stalls on RAW/WAW hazards or in-flight limits, serializes CSR and fence instructions, and applies valid/ready handshakes on both sides. Flush handling drops the held instruction without disturbing in-flight results.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/issue_scoreboard.sv | 65 ++++++
 rtl/issue_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: issue-stage defaults and FSM state type.
package riscv_pkg;

  localparam int RV_NB_UNIT         = 4;
  localparam int ISSUE_MAX_INFLIGHT = 4;
  localparam int ISSUE_PAYLOAD_W    = 64;

  typedef enum logic [1:0] {
    ISSUE_RUN    = 2'd0,
    ISSUE_DRAIN  = 2'd1,
    ISSUE_SERIAL = 2'd2
  } issue_state_t;

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-destination bitmap with in-flight counter and a three-operand hazard check.
module issue_scoreboard #(
  parameter int  MAX_INFLIGHT = 4,
  localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          set_v_i,
  input  logic [4:0]    set_adr_i,
  input  logic          wbk_v_i,
  input  logic [4:0]    wbk_adr_i,
  input  logic          rs1_v_i,
  input  logic [4:0]    rs1_adr_i,
  input  logic          rs2_v_i,
  input  logic [4:0]    rs2_adr_i,
  input  logic          rd_v_i,
  input  logic [4:0]    rd_adr_i,
  output logic          hazard_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] inflight_o,
  output logic [31:0]   sb_o
);

  logic [31:0]   sb_q, sb_d, sb_eff, clr_mask, set_mask;
  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic          clr_ok, set_ok, rd_real;

  // A writeback to an address that is not pending is ignored so the state stays consistent.
  assign clr_ok   = wbk_v_i & (wbk_adr_i != 5'd0) & sb_q[wbk_adr_i] & (cnt_q != '0);
  assign set_ok   = set_v_i & (set_adr_i != 5'd0);
  assign clr_mask = clr_ok ? (32'd1 << wbk_adr_i) : 32'd0;
  assign set_mask = set_ok ? (32'd1 << set_adr_i) : 32'd0;

  assign sb_eff  = sb_q & ~clr_mask;
  assign cnt_eff = cnt_q - CW'(clr_ok);
  assign sb_d    = sb_eff | set_mask;
  assign cnt_d   = cnt_eff + CW'(set_ok);

  assign rd_real  = rd_v_i & (rd_adr_i != 5'd0);
  assign hazard_o = (rs1_v_i & (rs1_adr_i != 5'd0) & sb_eff[rs1_adr_i]) |
                    (rs2_v_i & (rs2_adr_i != 5'd0) & sb_eff[rs2_adr_i]) |
                    (rd_real & sb_eff[rd_adr_i]);
  assign full_o   = rd_real & (cnt_eff == CW'(MAX_INFLIGHT));
  assign empty_o  = (sb_eff == 32'd0);

  assign inflight_o = cnt_q;
  assign sb_o       = sb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q  <= 32'd0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  wbk_pending_a: assert property (@(posedge clk) disable iff (!reset_n)
    (wbk_v_i && (wbk_adr_i != 5'd0)) |-> (sb_q[wbk_adr_i] && (cnt_q != '0)));
`endif

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue stage: one-entry issue register, hazard/serialization FSM and
// valid/ready handshakes toward decode and execute.
module issue_ctrl
  import riscv_pkg::*;
#(
  parameter int NB_UNIT      = RV_NB_UNIT,
  parameter int PAYLOAD_W    = ISSUE_PAYLOAD_W,
  parameter int MAX_INFLIGHT = ISSUE_MAX_INFLIGHT
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              dec_valid_i,
  output logic                              dec_ready_o,
  input  logic                              dec_rd_v_i,
  input  logic                              dec_rs1_v_i,
  input  logic                              dec_rs2_v_i,
  input  logic [4:0]                        dec_rd_adr_i,
  input  logic [4:0]                        dec_rs1_adr_i,
  input  logic [4:0]                        dec_rs2_adr_i,
  input  logic                              dec_serial_i,
  input  logic [NB_UNIT-1:0]                dec_unit_i,
  input  logic [PAYLOAD_W-1:0]              dec_payload_i,
  output logic                              iss_valid_o,
  input  logic                              iss_ready_i,
  output logic                              iss_rd_v_o,
  output logic [4:0]                        iss_rd_adr_o,
  output logic [4:0]                        iss_rs1_adr_o,
  output logic [4:0]                        iss_rs2_adr_o,
  output logic [NB_UNIT-1:0]                iss_unit_o,
  output logic [PAYLOAD_W-1:0]              iss_payload_o,
  input  logic                              wbk_v_i,
  input  logic [4:0]                        wbk_adr_i,
  input  logic                              flush_i,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
  output logic [1:0]                        dbg_state_o,
  output logic [31:0]                       dbg_sb_o
);

  localparam logic [1:0] ST_RUN    = 2'(ISSUE_RUN);
  localparam logic [1:0] ST_DRAIN  = 2'(ISSUE_DRAIN);
  localparam logic [1:0] ST_SERIAL = 2'(ISSUE_SERIAL);

  // Handshakes: a transfer happens on a cycle where valid & ready are both high;
  // iss_valid_o never depends on iss_ready_i and only drops early on flush_i.
  logic                 entry_v_q, entry_v_d;
  logic                 rd_v_q, rd_v_d, rs1_v_q, rs1_v_d, rs2_v_q, rs2_v_d;
  logic [4:0]           rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic                 serial_q, serial_d;
  logic [NB_UNIT-1:0]   unit_q, unit_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [1:0]           state_q, state_d;

  logic hazard, full, sb_empty, allow, issue_fire, capture;

  issue_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_v_i    (issue_fire & rd_v_q),
    .set_adr_i  (rd_q),
    .wbk_v_i    (wbk_v_i),
    .wbk_adr_i  (wbk_adr_i),
    .rs1_v_i    (rs1_v_q),
    .rs1_adr_i  (rs1_q),
    .rs2_v_i    (rs2_v_q),
    .rs2_adr_i  (rs2_q),
    .rd_v_i     (rd_v_q),
    .rd_adr_i   (rd_q),
    .hazard_o   (hazard),
    .full_o     (full),
    .empty_o    (sb_empty),
    .inflight_o (inflight_o),
    .sb_o       (dbg_sb_o)
  );

  // Serial instructions need an empty scoreboard both before and after they issue.
  always_comb begin
    allow = 1'b0;
    unique case (state_q)
      ST_RUN:              allow = ~serial_q | sb_empty;
      ST_DRAIN, ST_SERIAL: allow = sb_empty;
      default:             allow = 1'b0;
    endcase
  end

  assign iss_valid_o = entry_v_q & ~hazard & ~full & ~flush_i & allow;
  assign issue_fire  = iss_valid_o & iss_ready_i;
  assign dec_ready_o = ~flush_i & (~entry_v_q | issue_fire);
  assign capture     = dec_valid_i & dec_ready_o;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_RUN;
    end else if (issue_fire) begin
      state_d = serial_q ? ST_SERIAL : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN:    if (entry_v_q & serial_q & ~sb_empty) state_d = ST_DRAIN;
        ST_DRAIN:  state_d = ST_DRAIN;
        ST_SERIAL: if (sb_empty) state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    entry_v_d = entry_v_q;
    rd_v_d    = rd_v_q;
    rd_d      = rd_q;
    rs1_v_d   = rs1_v_q;
    rs1_d     = rs1_q;
    rs2_v_d   = rs2_v_q;
    rs2_d     = rs2_q;
    serial_d  = serial_q;
    unit_d    = unit_q;
    payload_d = payload_q;
    if (flush_i) begin
      entry_v_d = 1'b0;
    end else if (capture) begin
      entry_v_d = 1'b1;
      rd_v_d    = dec_rd_v_i;
      rd_d      = dec_rd_adr_i;
      rs1_v_d   = dec_rs1_v_i;
      rs1_d     = dec_rs1_adr_i;
      rs2_v_d   = dec_rs2_v_i;
      rs2_d     = dec_rs2_adr_i;
      serial_d  = dec_serial_i;
      unit_d    = dec_unit_i;
      payload_d = dec_payload_i;
    end else if (issue_fire) begin
      entry_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_v_q <= 1'b0;
      rd_v_q    <= 1'b0;
      rd_q      <= 5'd0;
      rs1_v_q   <= 1'b0;
      rs1_q     <= 5'd0;
      rs2_v_q   <= 1'b0;
      rs2_q     <= 5'd0;
      serial_q  <= 1'b0;
      unit_q    <= '0;
      payload_q <= '0;
      state_q   <= ST_RUN;
    end else begin
      entry_v_q <= entry_v_d;
      rd_v_q    <= rd_v_d;
      rd_q      <= rd_d;
      rs1_v_q   <= rs1_v_d;
      rs1_q     <= rs1_d;
      rs2_v_q   <= rs2_v_d;
      rs2_q     <= rs2_d;
      serial_q  <= serial_d;
      unit_q    <= unit_d;
      payload_q <= payload_d;
      state_q   <= state_d;
    end
  end

  assign iss_rd_v_o    = rd_v_q;
  assign iss_rd_adr_o  = rd_q;
  assign iss_rs1_adr_o = rs1_q;
  assign iss_rs2_adr_o = rs2_q;
  assign iss_unit_o    = unit_q;
  assign iss_payload_o = payload_q;
  assign dbg_state_o   = state_q;

endmodule
